// File: rtl/sqr_iter_8bit.sv
// Sequential shift-add squarer: W-bit root -> 2W-bit square over W iterations.
// Optional residual/root-validity check enabled by defining SQR_RESID_EN.
module sqr_iter_8bit #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   root,
`ifdef SQR_RESID_EN
  input  logic [2*W-1:0] radicand,
  output logic [W:0]     resid,
  output logic           root_ok,
`endif
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] square
);

  localparam int CNT_W = $clog2(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [2*W-1:0]   acc;
  logic [2*W-1:0]   mcand;
  logic [W-1:0]     mult;
  logic [CNT_W-1:0] cnt;
  logic [2*W-1:0]   sum;

`ifdef SQR_RESID_EN
  logic [W-1:0]     root_cap;
  logic [2*W-1:0]   rad_cap;
  logic [2*W:0]     diff;
  logic             fits;
`endif

  // Accumulator plus the current partial product (the final square on the last step).
  always_comb begin
    sum = acc;
    if (mult[0]) begin
      sum = acc + mcand;
    end else begin
      sum = acc;
    end
  end

`ifdef SQR_RESID_EN
  // Remainder against the captured radicand; the top bit of diff is the borrow.
  always_comb begin
    diff = {1'b0, rad_cap} - {1'b0, sum};
    fits = 1'b0;
    if (!diff[2*W] && (diff[2*W-1:0] <= {{(W-1){1'b0}}, root_cap, 1'b0})) begin
      fits = 1'b1;
    end else begin
      fits = 1'b0;
    end
  end
`endif

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      square <= {(2*W){1'b0}};
      acc    <= {(2*W){1'b0}};
      mcand  <= {(2*W){1'b0}};
      mult   <= {W{1'b0}};
      cnt    <= {CNT_W{1'b0}};
`ifdef SQR_RESID_EN
      resid    <= {(W+1){1'b0}};
      root_ok  <= 1'b0;
      root_cap <= {W{1'b0}};
      rad_cap  <= {(2*W){1'b0}};
`endif
    end else begin
      case (state)
        // The done cycle is also an acceptance slot, giving one result every W+1 cycles.
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= {{W{1'b0}}, root};
            mult  <= root;
            acc   <= {(2*W){1'b0}};
            cnt   <= {CNT_W{1'b0}};
            busy  <= 1'b1;
            state <= CALC;
`ifdef SQR_RESID_EN
            root_cap <= root;
            rad_cap  <= radicand;
`endif
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        CALC: begin
          acc   <= sum;
          mcand <= mcand << 1;
          mult  <= mult >> 1;
          cnt   <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt == CNT_W'(W - 1)) begin
            square <= sum;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
`ifdef SQR_RESID_EN
            root_ok <= fits;
            resid   <= fits ? diff[W:0] : {(W+1){1'b0}};
`endif
          end else begin
            state <= CALC;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqr_iter_8bit.sv
// Directed self-checking bench for sqr_iter_8bit; residual checks run when SQR_RESID_EN is defined.
module tb_sqr_iter_8bit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  root;
  logic        busy;
  logic        done;
  logic [15:0] square;
`ifdef SQR_RESID_EN
  logic [15:0] radicand;
  logic [8:0]  resid;
  logic        root_ok;
`endif

  int tests;
  int fails;

  sqr_iter_8bit #(.W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .root     (root),
`ifdef SQR_RESID_EN
    .radicand (radicand),
    .resid    (resid),
    .root_ok  (root_ok),
`endif
    .busy     (busy),
    .done     (done),
    .square   (square)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation from IDLE: checks latency, busy span, result and hold.
  task automatic do_op(input logic [7:0] r, input logic [15:0] exp, input string tag);
    int n;
    int busy_cnt;
    int overlap;
    root  = r;
    start = 1'b1;
    tick();
    start = 1'b0;
    root  = 8'h5A;
    n = 0;
    busy_cnt = 0;
    overlap = 0;
    while (!done && n < 20) begin
      if (busy) busy_cnt++;
      tick();
      n++;
    end
    if (busy && done) overlap = 1;
    check({tag, " latency"}, n, 32'd8);
    check({tag, " busy cycles"}, busy_cnt, 32'd8);
    check({tag, " busy at done"}, {31'd0, busy}, 32'd0);
    check({tag, " square"}, {16'd0, square}, {16'd0, exp});
    check({tag, " overlap"}, overlap, 32'd0);
    tick();
    check({tag, " done one cycle"}, {31'd0, done}, 32'd0);
    check({tag, " square held"}, {16'd0, square}, {16'd0, exp});
  endtask

`ifdef SQR_RESID_EN
  task automatic do_resid(input logic [15:0] rad, input logic [7:0] r, input logic [15:0] sq,
                          input logic [8:0] res, input logic ok, input string tag);
    radicand = rad;
    do_op(r, sq, tag);
    radicand = 16'h0000;
    check({tag, " resid"}, {23'd0, resid}, {23'd0, res});
    check({tag, " root_ok"}, {31'd0, root_ok}, {31'd0, ok});
  endtask
`endif

  initial begin
    int done_cnt;
    int prev;
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    start = 1'b0;
    root  = 8'h00;
`ifdef SQR_RESID_EN
    radicand = 16'h0000;
`endif
    tick();
    tick();
    rst = 1'b0;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset square", {16'd0, square}, 32'd0);
    tick();

    // Basic squares and boundaries.
    do_op(8'd13, 16'h00A9, "sq13");
    do_op(8'd255, 16'hFE01, "sq255");
    do_op(8'd0, 16'h0000, "sq0");

    // Start during CALC is ignored.
    root  = 8'd13;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    root  = 8'd200;
    start = 1'b1;
    tick();
    start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        done_cnt++;
        check("ignored start square", {16'd0, square}, 32'd169);
      end
      tick();
    end
    check("ignored start done count", done_cnt, 32'd1);
    check("ignored start square held", {16'd0, square}, 32'd169);
    do_op(8'd200, 16'h9C40, "sq200");

    // Continuous start: one result per 9 cycles.
    root  = 8'd7;
    start = 1'b1;
    done_cnt = 0;
    prev = -1;
    for (int i = 0; i < 46; i++) begin
      tick();
      if (done) begin
        done_cnt++;
        check("cont square", {16'd0, square}, 32'd49);
        check("cont busy at done", {31'd0, busy}, 32'd0);
        if (prev >= 0) check("cont period", i - prev, 32'd9);
        else check("cont first latency", i, 32'd8);
        prev = i;
      end
    end
    start = 1'b0;
    check("cont done count", done_cnt, 32'd5);
    for (int i = 0; i < 12; i++) tick();

    // Reset during CALC aborts the operation.
    root  = 8'd255;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort square", {16'd0, square}, 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) done_cnt++;
    end
    check("abort no done", done_cnt, 32'd0);
    do_op(8'd3, 16'd9, "sq3");

`ifdef SQR_RESID_EN
    do_resid(16'd200, 8'd14, 16'd196, 9'd4, 1'b1, "res200_14");
    do_resid(16'd200, 8'd15, 16'd225, 9'd0, 1'b0, "res200_15");
    do_resid(16'd230, 8'd14, 16'd196, 9'd0, 1'b0, "res230_14");
    do_resid(16'd65535, 8'd255, 16'hFE01, 9'd510, 1'b1, "res65535_255");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
